adder_sum_accumulator: RTL and testbench
========================================

Name: adder_sum_accumulator

Overview:
- Downstream consumer of the ripple-carry adder's (DATA_WIDTH+1)-bit result.
- Accumulates COUNT consecutive sums into one wide total using a valid/ready handshake on input and output.
- Presents the total with a saturation/overflow flag.
- Lets the adder datapath be reused for multi-word summation without extra combinational width.

Parameters:
- DATA_WIDTH, 8, adder operand width; the input sum is DATA_WIDTH+1 bits.
- COUNT, 4, number of input sums per batch; legal range 2..255.
- ACC_WIDTH, 11, accumulator width; must be >= DATA_WIDTH+1.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous active-high reset.
- clear  input  1  synchronous batch abort; returns the block to IDLE.
- in_valid  input  1  result_in is valid.
- in_ready  output  1  block accepts result_in this cycle.
- result_in  input  DATA_WIDTH+1  sum from the adder stage, unsigned.
- out_valid  output  1  acc_out and overflow are valid.
- out_ready  input  1  consumer accepts acc_out.
- acc_out  output  ACC_WIDTH  accumulated batch total, unsigned.
- overflow  output  1  the batch total exceeded 2^ACC_WIDTH-1; acc_out is saturated.
- sample_count  output  8  number of samples accepted in the current batch.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - acc_out=0, overflow=0, sample_count=0, out_valid=0.
  - in_ready=0 while rst is high; in_ready=1 from the first cycle after rst deasserts.
- Input accept: a sample is accepted when in_valid && in_ready at the clock edge.
- out_valid is registered. Output accept: out_valid && out_ready at the clock edge.
- IDLE:
  - in_ready=1.
  - On accept: acc_out <= zero-extended result_in, sample_count <= 1, overflow <= 0, go to ACCUM.
- ACCUM:
  - in_ready=1.
  - On accept: sum = acc_out + result_in, computed at ACC_WIDTH+1 bits.
  - If bit ACC_WIDTH of sum is set, or overflow is already set: acc_out <= all ones and overflow <= 1 (sticky, saturating).
  - Otherwise acc_out <= sum[ACC_WIDTH-1:0].
  - sample_count increments on every accept.
  - When the accepted sample is number COUNT: go to DONE and assert out_valid on the next cycle. Latency from the last input accept to out_valid is 1 cycle.
  - With no input accepted, all state holds. Gaps in in_valid are allowed.
- DONE:
  - in_ready=0, out_valid=1.
  - acc_out, overflow and sample_count (=COUNT) are stable until the output handshake.
  - On output accept: out_valid <= 0, sample_count <= 0, go to IDLE.
  - acc_out and overflow keep the last batch's values until the next first accept overwrites them.
  - No bubble is required beyond the one cycle spent in IDLE.
- clear:
  - In any state, clear=1 at an edge forces state=IDLE, sample_count=0, out_valid=0, acc_out=0, overflow=0.
  - in_ready=0 while clear=1, so a simultaneous in_valid is not accepted and the sample is dropped.
  - clear takes priority over the output handshake.
- rst asserted mid-batch or in DONE clears everything immediately (asynchronous). No partial result is emitted.
- in_ready is combinational from state and clear only. It never depends on in_valid.
- out_valid never deasserts without an output accept, clear or rst.
- Boundary values:
  - result_in=0 is legal and counts as a sample.
  - COUNT samples of maximum value fit exactly when ACC_WIDTH >= DATA_WIDTH+1+clog2(COUNT).
  - Smaller ACC_WIDTH values use the saturation rule.

Test Plan:
- Basic batch, defaults: accept 0x003, 0x010, 0x100, 0x0FF back to back -> 1 cycle after the 4th accept, out_valid=1, acc_out=0x212, overflow=0, sample_count=4; with out_ready=1 the block returns to IDLE with in_ready=1 next cycle.
- Maximum values, defaults: four samples of 0x1FF with random in_valid gaps -> acc_out=0x7FC (2044), overflow=0; sample_count steps 1,2,3,4 exactly on the accept edges.
- Saturation, ACC_WIDTH=10: samples 0x1FF, 0x1FF, 0x1FF, 0x001 -> the 3rd accept sets overflow=1 and acc_out=0x3FF; the 4th holds acc_out=0x3FF; the output shows acc_out=0x3FF, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 -> in_ready=0 throughout, outputs stable, no sample counted; on the out_ready=1 edge the block goes to IDLE and the next sample starts a new batch with acc_out=result_in.
- Clear mid-batch: after 2 accepts, assert clear together with in_valid=1 and result_in=0x055 -> that sample is not accepted, sample_count=0, acc_out=0, state IDLE; a following 4-sample batch totals correctly.
- Async reset: assert rst between clock edges while in DONE with acc_out=0x212 -> out_valid, acc_out, overflow and sample_count go to 0 immediately, without waiting for a clock edge; after deassertion in_ready=1 and normal operation resumes.

Source files
------------

// File: rtl/adder_sum_accumulator.sv
// Accumulates COUNT unsigned adder sums into one saturating ACC_WIDTH total,
// with valid/ready handshakes on both the sample input and the batch output.
module adder_sum_accumulator #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned COUNT      = 4,
    parameter int unsigned ACC_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH:0]   result_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  acc_out,
    output logic                  overflow,
    output logic [7:0]            sample_count
);

    localparam int unsigned SUM_W = ACC_WIDTH + 1;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    logic                 accept_c;
    logic                 last_sample_c;
    logic [SUM_W-1:0]     sum_c;

    // Ready depends only on state, clear and reset so it never loops through in_valid.
    assign in_ready      = !rst && !clear && (state != DONE);
    assign accept_c      = in_valid && in_ready;
    assign last_sample_c = (sample_count == CNT_W'(COUNT - 1));
    assign sum_c         = {1'b0, acc_out} + SUM_W'(result_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            acc_out      <= '0;
            overflow     <= 1'b0;
            sample_count <= '0;
            out_valid    <= 1'b0;
        end else if (clear) begin
            state        <= IDLE;
            acc_out      <= '0;
            overflow     <= 1'b0;
            sample_count <= '0;
            out_valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        acc_out      <= ACC_WIDTH'(result_in);
                        overflow     <= 1'b0;
                        sample_count <= CNT_W'(1);
                        state        <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept_c) begin
                        // Overflow is sticky: once saturated the total stays pinned at all ones.
                        if (sum_c[ACC_WIDTH] || overflow) begin
                            acc_out  <= '1;
                            overflow <= 1'b1;
                        end else begin
                            acc_out  <= sum_c[ACC_WIDTH-1:0];
                        end
                        sample_count <= sample_count + CNT_W'(1);
                        if (last_sample_c) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // acc_out/overflow survive the handshake until the next batch starts.
                    if (out_ready) begin
                        out_valid    <= 1'b0;
                        sample_count <= '0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Bench for adder_sum_accumulator: a default instance and a narrow-accumulator
// instance share stimulus and are checked against a batch-total reference model.
module tb_adder_sum_accumulator;

    localparam int unsigned DW    = 8;
    localparam int unsigned CNT   = 4;
    localparam int unsigned AW_A  = 11;
    localparam int unsigned AW_B  = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW:0]   result_in = '0;
    logic          out_ready = 1'b0;

    logic          in_ready_a, out_valid_a, overflow_a;
    logic [AW_A-1:0] acc_out_a;
    logic [7:0]    sample_count_a;
    logic          in_ready_b, out_valid_b, overflow_b;
    logic [AW_B-1:0] acc_out_b;
    logic [7:0]    sample_count_b;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the batch as a sample count and an exact integer total.
    bit     m_done = 0;
    int     m_n = 0;
    longint m_total = 0;

    always #5 clk = ~clk;

    adder_sum_accumulator #(.DATA_WIDTH(DW), .COUNT(CNT), .ACC_WIDTH(AW_A)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_a),
        .result_in(result_in), .out_valid(out_valid_a), .out_ready(out_ready),
        .acc_out(acc_out_a), .overflow(overflow_a), .sample_count(sample_count_a)
    );

    adder_sum_accumulator #(.DATA_WIDTH(DW), .COUNT(CNT), .ACC_WIDTH(AW_B)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_b),
        .result_in(result_in), .out_valid(out_valid_b), .out_ready(out_ready),
        .acc_out(acc_out_b), .overflow(overflow_b), .sample_count(sample_count_b)
    );

    function automatic longint sat_max(input int w);
        return (64'sd1 <<< w) - 1;
    endfunction

    function automatic longint exp_acc(input int w);
        return (m_total > sat_max(w)) ? sat_max(w) : m_total;
    endfunction

    function automatic logic exp_ovf(input int w);
        return (m_total > sat_max(w)) ? 1'b1 : 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid_a",    32'(out_valid_a),    32'(m_done));
        chk("acc_out_a",      32'(acc_out_a),      32'(exp_acc(AW_A)));
        chk("overflow_a",     32'(overflow_a),     32'(exp_ovf(AW_A)));
        chk("sample_count_a", 32'(sample_count_a), 32'(m_n));
        chk("out_valid_b",    32'(out_valid_b),    32'(m_done));
        chk("acc_out_b",      32'(acc_out_b),      32'(exp_acc(AW_B)));
        chk("overflow_b",     32'(overflow_b),     32'(exp_ovf(AW_B)));
        chk("sample_count_b", 32'(sample_count_b), 32'(m_n));
    endtask

    task automatic model_reset();
        m_done  = 0;
        m_n     = 0;
        m_total = 0;
    endtask

    // One clock: drive inputs, check ready before the edge, advance the model, check after.
    task automatic step(input logic v, input logic [DW:0] d, input logic ordy, input logic clr);
        logic exp_rdy;
        logic acc;
        in_valid  = v;
        result_in = d;
        out_ready = ordy;
        clear     = clr;
        #1;
        exp_rdy = !clr && !m_done;
        chk("in_ready_a", 32'(in_ready_a), 32'(exp_rdy));
        chk("in_ready_b", 32'(in_ready_b), 32'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else if (m_done) begin
            if (ordy) begin
                m_done = 0;
                m_n    = 0;
            end
        end else if (acc) begin
            if (m_n == 0) m_total = longint'(d);
            else          m_total = m_total + longint'(d);
            m_n++;
            if (m_n == CNT) m_done = 1;
        end
        #1;
        check_outputs();
    endtask

    task automatic send_gappy(input logic [DW:0] d);
        int gaps;
        gaps = int'($urandom_range(0, 3));
        for (int g = 0; g < gaps; g++) step(1'b0, DW'($urandom) , 1'b1, 1'b0);
        step(1'b1, d, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset: outputs cleared and ready held low while rst is high.
        #3;
        check_outputs();
        chk("in_ready_rst_a", 32'(in_ready_a), 32'd0);
        chk("in_ready_rst_b", 32'(in_ready_b), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("in_ready_post_rst", 32'(in_ready_a), 32'd1);

        // Basic batch, back to back, then output accepted.
        step(1'b1, 9'h003, 1'b1, 1'b0);
        step(1'b1, 9'h010, 1'b1, 1'b0);
        step(1'b1, 9'h100, 1'b1, 1'b0);
        step(1'b1, 9'h0FF, 1'b1, 1'b0);
        chk("basic_total", 32'(acc_out_a), 32'h212);
        step(1'b0, 9'h000, 1'b1, 1'b0);

        // Maximum values with random gaps: narrow instance saturates.
        for (int i = 0; i < 4; i++) send_gappy(9'h1FF);
        chk("max_total", 32'(acc_out_a), 32'h7FC);
        step(1'b0, 9'h000, 1'b1, 1'b0);

        // Saturation sequence for the 10-bit instance.
        step(1'b1, 9'h1FF, 1'b1, 1'b0);
        step(1'b1, 9'h1FF, 1'b1, 1'b0);
        step(1'b1, 9'h1FF, 1'b1, 1'b0);
        chk("sat_third", 32'(acc_out_b), 32'h3FF);
        step(1'b1, 9'h001, 1'b0, 1'b0);
        chk("sat_ovf", 32'(overflow_b), 32'd1);

        // Backpressure in DONE with in_valid held high.
        for (int i = 0; i < 5; i++) step(1'b1, 9'h0AA, 1'b0, 1'b0);
        step(1'b1, 9'h0AA, 1'b1, 1'b0);
        step(1'b1, 9'h077, 1'b1, 1'b0);
        chk("new_batch_first", 32'(acc_out_a), 32'h077);

        // Clear mid-batch drops the coincident sample.
        step(1'b1, 9'h011, 1'b1, 1'b0);
        step(1'b1, 9'h055, 1'b1, 1'b1);
        chk("clear_count", 32'(sample_count_a), 32'd0);
        step(1'b1, 9'h001, 1'b1, 1'b0);
        step(1'b1, 9'h002, 1'b1, 1'b0);
        step(1'b1, 9'h004, 1'b1, 1'b0);
        step(1'b1, 9'h008, 1'b0, 1'b0);
        chk("after_clear_total", 32'(acc_out_a), 32'h00F);
        step(1'b0, 9'h000, 1'b1, 1'b0);

        // Async reset while DONE holds 0x212.
        step(1'b1, 9'h003, 1'b1, 1'b0);
        step(1'b1, 9'h010, 1'b1, 1'b0);
        step(1'b1, 9'h100, 1'b1, 1'b0);
        step(1'b1, 9'h0FF, 1'b0, 1'b0);
        chk("pre_rst_total", 32'(acc_out_a), 32'h212);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("in_ready_async_rst", 32'(in_ready_a), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("in_ready_resume", 32'(in_ready_a), 32'd1);

        // Randomized traffic including clears and output backpressure.
        for (int i = 0; i < 400; i++) begin
            logic [DW:0] d;
            d = ($urandom_range(0, 3) == 0) ? 9'h1FF : DW'($urandom) + 9'(($urandom_range(0, 1)) << DW);
            step(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 39) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
